// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word into IF/ID under reset > redirect > stall > wait priority.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC_out,
  input  logic [31:0] inst_in,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;

  // Reset is handled in the register process; this block only encodes the
  // redirect > stall > wait > normal priority.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    id_pc_d = id_pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      id_pc_d = 32'h0000_0000;
      inst_d  = NOP_INST;
    end else if (stall) begin
      // Hold everything; imem_ready is irrelevant while decode is stalled.
    end else if (!imem_ready) begin
      valid_d = 1'b0;
      id_pc_d = 32'h0000_0000;
      inst_d  = NOP_INST;
    end else begin
      pc_d    = pc_q + 32'd4;
      valid_d = 1'b1;
      id_pc_d = pc_q;
      inst_d  = inst_in;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      id_pc_q <= 32'h0000_0000;
      inst_q  <= NOP_INST;
      cnt_q   <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      id_pc_q <= id_pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_out      = pc_q;
  assign IF_ID_valid = valid_q;
  assign IF_ID_PC    = id_pc_q;
  assign IF_ID_Inst  = inst_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small asynchronous instruction memory feeds
// inst_in, and each step checks the registered outputs 1 ns after the edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_out;
  logic [31:0] inst_in;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Inst;
  logic [31:0] fetch_cnt;

  logic [31:0] imem [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign inst_in = imem[PC_out[7:2]];

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PC_out     (PC_out),
    .inst_in    (inst_in),
    .imem_ready (imem_ready),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .IF_ID_valid(IF_ID_valid),
    .IF_ID_PC   (IF_ID_PC),
    .IF_ID_Inst (IF_ID_Inst),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic v,
                           input logic [31:0] idpc, input logic [31:0] inst,
                           input logic [31:0] cnt);
    check({tag, ".pc"},   PC_out, pc);
    check({tag, ".vld"},  {31'd0, IF_ID_valid}, {31'd0, v});
    check({tag, ".idpc"}, IF_ID_PC, idpc);
    check({tag, ".inst"}, IF_ID_Inst, inst);
    check({tag, ".cnt"},  fetch_cnt, cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    imem[0]  = 32'h0050_0093;
    imem[1]  = 32'h0060_0113;
    imem[2]  = 32'h0020_81B3;
    imem[3]  = 32'h0000_0013;
    imem[16] = 32'h0010_0513;
    imem[63] = 32'h00A0_0593;

    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    step(); step();
    check_all("reset", 32'h0, 1'b0, 32'h0, 32'h13, 32'd0);

    // Free run from RESET_PC
    rst = 1'b0;
    step(); check_all("run0", 32'h4,  1'b1, 32'h0, 32'h0050_0093, 32'd1);
    step(); check_all("run1", 32'h8,  1'b1, 32'h4, 32'h0060_0113, 32'd2);
    step(); check_all("run2", 32'hC,  1'b1, 32'h8, 32'h0020_81B3, 32'd3);
    step(); check_all("run3", 32'h10, 1'b1, 32'hC, 32'h0000_0013, 32'd4);

    // Stall two cycles while IF_ID_PC = 4
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    check_all("prestall", 32'h8, 1'b1, 32'h4, 32'h0060_0113, 32'd2);
    stall = 1'b1;
    step(); check_all("stall1", 32'h8, 1'b1, 32'h4, 32'h0060_0113, 32'd2);
    step(); check_all("stall2", 32'h8, 1'b1, 32'h4, 32'h0060_0113, 32'd2);
    stall = 1'b0;
    step(); check_all("resume", 32'hC, 1'b1, 32'h8, 32'h0020_81B3, 32'd3);

    // Redirect with misaligned target while PC_out = 0xC
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    step(); check_all("redir", 32'h40, 1'b0, 32'h0, 32'h13, 32'd3);
    redirect = 1'b0;
    step(); check_all("redir+1", 32'h44, 1'b1, 32'h40, 32'h0010_0513, 32'd4);

    // Redirect and stall together: flush wins
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
    step(); check_all("redir_stall", 32'h20, 1'b0, 32'h0, 32'h13, 32'd4);
    stall = 1'b0; redirect_pc = 32'h8;
    step(); check_all("to8", 32'h8, 1'b0, 32'h0, 32'h13, 32'd4);
    redirect = 1'b0;

    // Memory wait: three bubbles, PC holds
    imem_ready = 1'b0;
    step(); check_all("wait1", 32'h8, 1'b0, 32'h0, 32'h13, 32'd4);
    step(); check_all("wait2", 32'h8, 1'b0, 32'h0, 32'h13, 32'd4);
    step(); check_all("wait3", 32'h8, 1'b0, 32'h0, 32'h13, 32'd4);
    imem_ready = 1'b1;
    step(); check_all("ready", 32'hC, 1'b1, 32'h8, 32'h0020_81B3, 32'd5);

    // Stall with wait: IF/ID keeps its instruction
    stall = 1'b1; imem_ready = 1'b0;
    step(); check_all("stall_wait", 32'hC, 1'b1, 32'h8, 32'h0020_81B3, 32'd5);
    stall = 1'b0; imem_ready = 1'b1;

    // PC wrap at top of address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); check_all("wrap_redir", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h13, 32'd5);
    redirect = 1'b0;
    step(); check_all("wrap0", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h00A0_0593, 32'd6);
    step(); check_all("wrap1", 32'h4, 1'b1, 32'h0, 32'h0050_0093, 32'd7);

    // Reset overrides concurrent stall and redirect
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step(); check_all("rst_mid", 32'h0, 1'b0, 32'h0, 32'h13, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. It owns the program counter and drives the instruction-memory address. It captures the returned instruction into the IF/ID register. It applies stall, redirect and memory-wait control from the downstream hazard and branch logic, so the decode stage receives a clean, valid-tagged instruction stream.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF_ID_Inst when no valid instruction is delivered.

Ports:
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- PC_out  output  32  instruction-memory address; equals internal PC register.
- inst_in  input  32  instruction word returned combinationally by instruction memory for PC_out.
- imem_ready  input  1  1 = inst_in is valid this cycle.
- stall  input  1  load-use hazard hold from decode.
- redirect  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target address for redirect.
- IF_ID_valid  output  1  decode-stage instruction valid.
- IF_ID_PC  output  32  PC of the IF/ID instruction.
- IF_ID_Inst  output  32  instruction in IF/ID.
- fetch_cnt  output  32  count of instructions delivered into IF/ID with valid=1.

## Operation
- Each rising edge applies exactly one action. Priority order: rst > redirect > stall > !imem_ready > normal.
- **rst:**
  - PC <= RESET_PC.
  - IF_ID_valid <= 0, IF_ID_PC <= 0, IF_ID_Inst <= NOP_INST.
  - fetch_cnt <= 0.
- **redirect:**
  - PC <= {redirect_pc[31:2], 2'b00}; the low two bits are always cleared.
  - IF/ID is flushed: valid 0, PC 0, Inst NOP_INST.
  - fetch_cnt holds.
  - The instruction on inst_in this cycle is discarded.
- **stall, with redirect=0:**
  - PC holds.
  - IF_ID_valid, IF_ID_PC and IF_ID_Inst all hold.
  - fetch_cnt holds.
  - imem_ready is ignored.
- **!imem_ready, with no stall and no redirect:**
  - PC holds.
  - IF/ID takes a bubble: valid 0, PC 0, Inst NOP_INST.
  - fetch_cnt holds.
- **Normal (imem_ready=1, no stall, no redirect):**
  - IF_ID_valid <= 1, IF_ID_PC <= PC, IF_ID_Inst <= inst_in.
  - PC <= PC + 4.
  - fetch_cnt <= fetch_cnt + 1.
- **Arithmetic:**
  - PC+4 is 32-bit modulo: 0xFFFF_FFFC wraps to 0x0000_0000 with no error indication.
  - fetch_cnt wraps from 0xFFFF_FFFF to 0.
- **Stall and wait together:** stall=1 with imem_ready=0 behaves as stall. IF/ID keeps its current instruction; no bubble is inserted.
- **Redirect during stall:** redirect=1 with stall=1 behaves as redirect. The flush wins; the stalled decode instruction is dropped.
- There is no internal state machine beyond the PC, IF/ID and counter registers. The block is a single-state pipeline register with priority-encoded update.

## Timing
- PC_out is a register output and is stable for the whole cycle. Instruction memory is asynchronous-read, so inst_in for PC_out is sampled on the same rising edge.
- Fetch-to-decode latency is 1 cycle: an instruction at PC_out in cycle n appears on IF_ID_* in cycle n+1.
- Redirect penalty:
  - Redirect asserted in cycle n gives PC_out = target in cycle n+1.
  - IF_ID_valid = 0 in cycle n+1.
  - The first target instruction is valid in IF/ID in cycle n+2.
- Reset is held for as long as rst=1. After the first edge with rst=0, IF_ID holds the instruction at RESET_PC (valid=1) if imem_ready=1.
- A reset arriving mid-stall or mid-redirect overrides both on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then free-run with imem_ready=1, IM[0..3]=0x00500093,0x00600113,0x002081B3,0x00000013 -> IF_ID_PC sequence 0,4,8,C on successive cycles with valid=1; fetch_cnt=4 after 4 cycles; PC_out=0x10.
- Assert stall for 2 cycles while IF_ID_PC=4 -> IF_ID_PC/Inst stay 4/0x00600113 and PC_out stays 8; fetch_cnt unchanged; normal flow resumes at 8.
- Assert redirect with redirect_pc=0x0000_0043 while PC_out=0xC -> next cycle PC_out=0x40 and IF_ID_valid=0 with IF_ID_Inst=0x00000013; the following cycle IF_ID_PC=0x40 with valid=1.
- Assert redirect and stall together, redirect_pc=0x20 -> flush occurs and PC_out=0x20; stall is ignored.
- Deassert imem_ready for 3 cycles at PC_out=0x8 -> three bubbles (valid=0, Inst 0x13); PC_out holds 8; fetch_cnt frozen. With stall=1 also, IF/ID instead holds its prior valid instruction.
- Redirect to 0xFFFF_FFFC and run 2 cycles -> IF_ID_PC=0xFFFF_FFFC, then PC_out wraps to 0x0000_0000; assert rst mid-sequence -> next edge PC_out=RESET_PC, IF_ID_valid=0, fetch_cnt=0.
